// File: rtl/recurrence_engine.sv
// -----------------------------------------------------------------------------
// recurrence_engine
//
// Evaluates the two-term recurrence v[n] = A*v[n-1] + B*v[n-2] for a requested
// index n, with A, B, v[0] and v[1] supplied per request. Computed values are
// kept in a memo table together with a high-water mark (hw), so a request at
// or below hw under an unchanged configuration completes without computing
// anything new. A request for a higher index under the same configuration
// extends the table from hw onwards.
//
// Ports
//   clk       rising-edge clock
//   rst       asynchronous, active-low reset
//   start     request strobe, sampled only while idle
//   entry     requested index n
//   coef_a    coefficient A (unsigned)
//   coef_b    coefficient B (unsigned)
//   seed0     v[0]
//   seed1     v[1]
//   busy      high from the accepting edge until the completion edge
//   done      one-cycle completion pulse
//   result    v[entry] mod 2^VAL_W, held until the next done
//   overflow  v[entry] or one of its ancestors needed more than VAL_W bits
//   hit       request completed without computing a new index
//   error     entry exceeded MAX_N (result/overflow/hit forced to 0)
//
// Timing: start accepted at edge T0, done is high in the cycle following edge
// T0+2+C, where C is the number of indices computed. A new start is accepted
// in the same cycle that done is high, giving 3+C cycles per request.
// -----------------------------------------------------------------------------
module recurrence_engine #(
  parameter int IDX_W  = 4,
  parameter int MAX_N  = 15,
  parameter int VAL_W  = 21,
  parameter int COEF_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [IDX_W-1:0]  entry,
  input  logic [COEF_W-1:0] coef_a,
  input  logic [COEF_W-1:0] coef_b,
  input  logic [VAL_W-1:0]  seed0,
  input  logic [VAL_W-1:0]  seed1,
  output logic              busy,
  output logic              done,
  output logic [VAL_W-1:0]  result,
  output logic              overflow,
  output logic              hit,
  output logic              error
);

  // Wide enough for A*x + B*y with A, B < 2^COEF_W and x, y < 2^VAL_W.
  localparam int FULL_W = VAL_W + COEF_W + 1;
  localparam int CFG_W  = 2 * COEF_W + 2 * VAL_W;
  // MAX_N held one bit wider than an index so the range check is never a
  // compare against the all-ones value of the index type.
  localparam logic [IDX_W:0] MAX_N_X = (IDX_W + 1)'(MAX_N);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CALC = 2'd2,
    DONE = 2'd3
  } state_t;

  // One recurrence step at full precision; operands are zero-extended first
  // so the products are not truncated to the operand width.
  function automatic logic [FULL_W-1:0] step_full(
    input logic [COEF_W-1:0] a,
    input logic [COEF_W-1:0] b,
    input logic [VAL_W-1:0]  x1,
    input logic [VAL_W-1:0]  x2
  );
    logic [FULL_W-1:0] ea;
    logic [FULL_W-1:0] eb;
    logic [FULL_W-1:0] ex1;
    logic [FULL_W-1:0] ex2;
    ea  = {{(FULL_W - COEF_W){1'b0}}, a};
    eb  = {{(FULL_W - COEF_W){1'b0}}, b};
    ex1 = {{(FULL_W - VAL_W){1'b0}}, x1};
    ex2 = {{(FULL_W - VAL_W){1'b0}}, x2};
    return (ea * ex1) + (eb * ex2);
  endfunction

  // True when a full-precision step no longer fits in VAL_W bits.
  function automatic logic exceeds_val(input logic [FULL_W-1:0] f);
    return |f[FULL_W-1:VAL_W];
  endfunction

  state_t              state;

  // Request latched at the accepting edge; later input changes are ignored.
  logic [IDX_W-1:0]    entry_q;
  logic [COEF_W-1:0]   a_q;
  logic [COEF_W-1:0]   b_q;
  logic [VAL_W-1:0]    s0_q;
  logic [VAL_W-1:0]    s1_q;
  logic                err_q;
  logic                calc_ran;

  // Memo bookkeeping: configuration the table was built with, its validity
  // and the highest index currently held.
  logic [CFG_W-1:0]    cfg_mem;
  logic                valid;
  logic [IDX_W-1:0]    hw;

  // Memo storage. Contents are qualified by valid/hw, so they need no reset.
  logic [VAL_W-1:0]    tbl [0:MAX_N];
  logic                ovf [0:MAX_N];

  logic [CFG_W-1:0]    cfg_cur;
  logic                entry_bad;
  logic                reload;
  logic [IDX_W-1:0]    hw_eff;
  logic [IDX_W-1:0]    idx_new;
  logic [IDX_W-1:0]    idx_m1;
  logic [FULL_W-1:0]   full;
  logic                load_wr;
  logic                calc_wr;

  always_comb begin
    cfg_cur   = {a_q, b_q, s0_q, s1_q};
    entry_bad = {1'b0, entry_q} > MAX_N_X;
    reload    = !valid || (cfg_cur != cfg_mem);
    // hw as it will stand after LOAD, used to decide whether CALC is needed.
    hw_eff    = reload ? IDX_W'(1) : hw;
    idx_new   = hw + IDX_W'(1);
    idx_m1    = hw - IDX_W'(1);
    full      = step_full(a_q, b_q, tbl[hw], tbl[idx_m1]);
    load_wr   = (state == LOAD) && !entry_bad && reload;
    calc_wr   = (state == CALC);
  end

  // Table write port: seeding on a (re)load, one new index per CALC cycle.
  always_ff @(posedge clk) begin
    if (load_wr) begin
      tbl[0] <= s0_q;
      tbl[1] <= s1_q;
      ovf[0] <= 1'b0;
      ovf[1] <= 1'b0;
    end else if (calc_wr) begin
      tbl[idx_new] <= full[VAL_W-1:0];
      ovf[idx_new] <= ovf[hw] | ovf[idx_m1] | exceeds_val(full);
    end
  end

  // Control FSM with registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      entry_q  <= '0;
      a_q      <= '0;
      b_q      <= '0;
      s0_q     <= '0;
      s1_q     <= '0;
      err_q    <= 1'b0;
      calc_ran <= 1'b0;
      cfg_mem  <= '0;
      valid    <= 1'b0;
      hw       <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= '0;
      overflow <= 1'b0;
      hit      <= 1'b0;
      error    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            entry_q  <= entry;
            a_q      <= coef_a;
            b_q      <= coef_b;
            s0_q     <= seed0;
            s1_q     <= seed1;
            err_q    <= 1'b0;
            calc_ran <= 1'b0;
            busy     <= 1'b1;
            state    <= LOAD;
          end
        end

        // ---- LOAD: range check, reseed on a configuration change ----
        LOAD: begin
          if (entry_bad) begin
            err_q <= 1'b1;
            state <= DONE;
          end else begin
            if (reload) begin
              hw      <= IDX_W'(1);
              valid   <= 1'b1;
              cfg_mem <= cfg_cur;
            end
            state <= (entry_q > hw_eff) ? CALC : DONE;
          end
        end

        // ---- CALC: extend the table by one index per cycle ----
        CALC: begin
          hw       <= idx_new;
          calc_ran <= 1'b1;
          if (idx_new == entry_q) begin
            state <= DONE;
          end
        end

        // ---- DONE: publish the result, release busy ----
        DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          error <= err_q;
          if (err_q) begin
            result   <= '0;
            overflow <= 1'b0;
            hit      <= 1'b0;
          end else begin
            result   <= tbl[entry_q];
            overflow <= ovf[entry_q];
            hit      <= !calc_ran;
          end
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_recurrence_engine.sv
// -----------------------------------------------------------------------------
// tb_recurrence_engine
//
// Two instances: u_dut0 with MAX_N=15 and u_dut1 with MAX_N=12 (the latter
// makes out-of-range indices reachable with a 4-bit entry). Requests are
// issued by a stimulus process that pushes the expected completion (value,
// flags and the cycle in which done must appear) into a per-instance queue;
// a monitor pops and compares whenever done is seen.
//
// The reference model keeps only the memo state that decides how many new
// indices a request needs (valid, high-water mark, configuration) and
// recomputes the sequence from the seeds with plain integer arithmetic.
// -----------------------------------------------------------------------------
module tb_recurrence_engine;

  localparam int IDX_W  = 4;
  localparam int VAL_W  = 21;
  localparam int COEF_W = 4;
  localparam longint LIM = longint'(1) << VAL_W;

  typedef struct {
    longint res;
    bit     ovf;
    bit     hit;
    bit     err;
    int     cyc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst;
  logic                start_s [2];
  logic [IDX_W-1:0]    entry_s [2];
  logic [COEF_W-1:0]   a_s     [2];
  logic [COEF_W-1:0]   b_s     [2];
  logic [VAL_W-1:0]    s0_s    [2];
  logic [VAL_W-1:0]    s1_s    [2];
  logic                busy_s  [2];
  logic                done_s  [2];
  logic [VAL_W-1:0]    res_s   [2];
  logic                ovf_s   [2];
  logic                hit_s   [2];
  logic                err_s   [2];

  recurrence_engine #(.IDX_W(IDX_W), .MAX_N(15), .VAL_W(VAL_W), .COEF_W(COEF_W)) u_dut0 (
    .clk(clk), .rst(rst), .start(start_s[0]), .entry(entry_s[0]),
    .coef_a(a_s[0]), .coef_b(b_s[0]), .seed0(s0_s[0]), .seed1(s1_s[0]),
    .busy(busy_s[0]), .done(done_s[0]), .result(res_s[0]),
    .overflow(ovf_s[0]), .hit(hit_s[0]), .error(err_s[0])
  );

  recurrence_engine #(.IDX_W(IDX_W), .MAX_N(12), .VAL_W(VAL_W), .COEF_W(COEF_W)) u_dut1 (
    .clk(clk), .rst(rst), .start(start_s[1]), .entry(entry_s[1]),
    .coef_a(a_s[1]), .coef_b(b_s[1]), .seed0(s0_s[1]), .seed1(s1_s[1]),
    .busy(busy_s[1]), .done(done_s[1]), .result(res_s[1]),
    .overflow(ovf_s[1]), .hit(hit_s[1]), .error(err_s[1])
  );

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  exp_t q0[$];
  exp_t q1[$];

  // Model memo state per instance.
  bit          m_valid [2];
  int          m_hw    [2];
  logic [49:0] m_key   [2];

  task automatic check(input string name, input longint act, input longint req);
    n_cmp++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // v[n] and its overflow history from the seeds, by direct evaluation.
  function automatic void ref_seq(input int a, input int b, input longint s0,
                                  input longint s1, input int n,
                                  output longint v, output bit o);
    longint x [0:15];
    bit     f [0:15];
    longint full;
    x[0] = s0; x[1] = s1; f[0] = 1'b0; f[1] = 1'b0;
    for (int i = 2; i <= n; i++) begin
      full = a * x[i-1] + b * x[i-2];
      x[i] = full % LIM;
      f[i] = f[i-1] | f[i-2] | (full >= LIM);
    end
    v = x[n];
    o = f[n];
  endfunction

  // Expected completion of one request; updates the model memo state.
  function automatic void model_req(input int k, input int entry, input int a,
                                    input int b, input longint s0, input longint s1,
                                    output exp_t e, output int c);
    int          maxn;
    logic [49:0] key;
    longint      v;
    bit          o;
    maxn = (k == 0) ? 15 : 12;
    e.cyc = 0;
    if (entry > maxn) begin
      e.res = 0; e.ovf = 1'b0; e.hit = 1'b0; e.err = 1'b1;
      c = 0;
    end else begin
      key = {COEF_W'(a), COEF_W'(b), VAL_W'(s0), VAL_W'(s1)};
      if (!m_valid[k] || m_key[k] != key) begin
        m_valid[k] = 1'b1;
        m_key[k]   = key;
        m_hw[k]    = 1;
      end
      c = (entry > m_hw[k]) ? entry - m_hw[k] : 0;
      if (entry > m_hw[k]) m_hw[k] = entry;
      ref_seq(a, b, s0, s1, entry, v, o);
      e.res = v; e.ovf = o; e.hit = (c == 0); e.err = 1'b0;
    end
  endfunction

  // Monitor: every done must match the oldest outstanding expectation.
  task automatic mon(input int k);
    exp_t e;
    string p;
    p = (k == 0) ? "dut0" : "dut1";
    if ((k == 0 && q0.size() == 0) || (k == 1 && q1.size() == 0)) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s unexpected_done: done=1 at cycle %0d, required no done", p, cyc);
    end else begin
      if (k == 0) e = q0.pop_front();
      else        e = q1.pop_front();
      check({p, " result"},   res_s[k],  e.res);
      check({p, " overflow"}, ovf_s[k],  e.ovf);
      check({p, " hit"},      hit_s[k],  e.hit);
      check({p, " error"},    err_s[k],  e.err);
      check({p, " done_cycle"}, cyc,     e.cyc);
      check({p, " busy_at_done"}, busy_s[k], 0);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      if (done_s[0]) mon(0);
      if (done_s[1]) mon(1);
    end
  end

  task automatic scramble(input int k);
    entry_s[k] = IDX_W'($urandom);
    a_s[k]     = COEF_W'($urandom);
    b_s[k]     = COEF_W'($urandom);
    s0_s[k]    = VAL_W'($urandom);
    s1_s[k]    = VAL_W'($urandom);
  endtask

  // Issue one request at a negedge with the instance idle. With wt=1, returns
  // at the negedge where done is high (so the next call is back-to-back).
  // With noise=1, extra start pulses with random inputs are applied while busy.
  task automatic issue(input int k, input int entry, input int a, input int b,
                       input longint s0, input longint s1, input bit wt, input bit noise);
    exp_t e;
    int   c;
    bit   seen;
    model_req(k, entry, a, b, s0, s1, e, c);
    start_s[k] = 1'b1;
    entry_s[k] = IDX_W'(entry);
    a_s[k]     = COEF_W'(a);
    b_s[k]     = COEF_W'(b);
    s0_s[k]    = VAL_W'(s0);
    s1_s[k]    = VAL_W'(s1);
    @(posedge clk);
    #1;
    e.cyc = cyc + 2 + c;
    if (k == 0) q0.push_back(e);
    else        q1.push_back(e);
    start_s[k] = 1'b0;
    scramble(k);
    check("busy_after_start", busy_s[k], 1);
    if (wt) begin
      seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
        @(negedge clk);
        start_s[k] = 1'b0;
        if (done_s[k]) begin
          seen = 1'b1;
        end else if (noise && busy_s[k]) begin
          start_s[k] = 1'($urandom);
          scramble(k);
        end
      end
      if (!seen) begin
        n_cmp++;
        n_fail++;
        $display("FAIL done_timeout: no done within 40 cycles for entry %0d, required done", entry);
      end
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_valid[k] = 1'b0;
      m_hw[k]    = 0;
      m_key[k]   = '0;
    end
    q0.delete();
    q1.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, e, a, b;
    longint s0, s1;
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      start_s[i] = 1'b0; entry_s[i] = '0; a_s[i] = '0; b_s[i] = '0;
      s0_s[i] = '0; s1_s[i] = '0;
    end
    model_reset();
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check("reset busy",     busy_s[i], 0);
      check("reset done",     done_s[i], 0);
      check("reset result",   res_s[i],  0);
      check("reset overflow", ovf_s[i],  0);
      check("reset hit",      hit_s[i],  0);
      check("reset error",    err_s[i],  0);
    end
    rst = 1'b1;
    @(negedge clk);

    // Directed: memo reuse, extension, reload, overflow boundary.
    issue(0, 4,  2, 3, 1, 1, 1, 0);
    issue(0, 2,  2, 3, 1, 1, 1, 0);
    issue(0, 6,  2, 3, 1, 1, 1, 0);
    issue(0, 10, 1, 1, 0, 1, 1, 0);
    issue(0, 4,  2, 3, 1, 1, 1, 0);
    issue(0, 13, 2, 3, 1, 1, 1, 0);
    issue(0, 14, 2, 3, 1, 1, 1, 0);
    issue(0, 15, 2, 3, 1, 1, 1, 0);
    issue(0, 15, 2, 3, 1, 1, 1, 0);
    issue(0, 0,  2, 3, 1, 1, 1, 0);
    issue(0, 1,  2, 3, 1, 1, 1, 0);

    // Directed: out-of-range index on the MAX_N=12 instance.
    issue(1, 13, 2, 3, 1, 1, 1, 0);
    issue(1, 4,  2, 3, 1, 1, 1, 0);
    issue(1, 12, 2, 3, 1, 1, 1, 0);
    issue(1, 15, 2, 3, 1, 1, 1, 0);

    // Reset during CALC: outputs clear at once, no done, table invalidated.
    @(negedge clk);
    issue(0, 15, 1, 2, 3, 5, 0, 0);
    repeat (4) @(negedge clk);
    rst = 1'b0;
    model_reset();
    #1;
    check("midrun_reset busy",   busy_s[0], 0);
    check("midrun_reset done",   done_s[0], 0);
    check("midrun_reset result", res_s[0],  0);
    check("midrun_reset hit",    hit_s[0],  0);
    @(negedge clk);
    rst = 1'b1;
    repeat (20) @(negedge clk);
    issue(0, 4, 2, 3, 1, 1, 1, 0);

    // Handshake noise: start pulses while busy must be ignored.
    issue(0, 9,  2, 3, 1, 1, 1, 1);
    issue(0, 12, 3, 1, 2, 7, 1, 1);
    issue(0, 5,  3, 1, 2, 7, 1, 1);

    // Randomised: small configuration pool to exercise memo reuse.
    for (int n = 0; n < 80; n++) begin
      k  = ($urandom_range(0, 3) == 0) ? 1 : 0;
      e  = $urandom_range(0, 15);
      a  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : $urandom_range(1, 3);
      b  = $urandom_range(0, 3);
      s0 = $urandom_range(0, 2);
      s1 = ($urandom_range(0, 7) == 0) ? longint'($urandom_range(0, 2097151)) : longint'($urandom_range(1, 2));
      if ($urandom_range(0, 1) == 1) begin
        a = 2; b = 3; s0 = 1; s1 = 1;
      end
      issue(k, e, a, b, s0, s1, 1, 1'($urandom));
    end

    repeat (5) @(negedge clk);
    check("dut0 outstanding", q0.size(), 0);
    check("dut1 outstanding", q1.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
